// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and formatter FSM states.
// Segment bit 0 = a ... bit 6 = g, active-high.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int          NUM_DIGITS  = 8;
  localparam logic [31:0] MAX_DISPLAY = 32'd99_999_999;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ENCODE
  } state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to seven-segment pattern decoder.
// Non-decimal nibbles decode to a dash so corrupted digits are visible.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_value_formatter.sv
// Binary to 8-digit seven-segment formatter: iterative double-dabble,
// one shift per clock, then an atomic update of all eight digit patterns.
module seg_value_formatter
  import seg7_pkg::*;
#(
  parameter int WIDTH    = 27,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic             iCLK,
  input  logic             nRST,
  input  logic             iSTART,
  input  logic [WIDTH-1:0] iVALUE,
  output logic             oBUSY,
  output logic             oDONE,
  output logic [6:0]       oSEG7,
  output logic [6:0]       oSEG6,
  output logic [6:0]       oSEG5,
  output logic [6:0]       oSEG4,
  output logic [6:0]       oSEG3,
  output logic [6:0]       oSEG2,
  output logic [6:0]       oSEG1,
  output logic [6:0]       oSEG0
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t                          r_state, w_state_nxt;
  logic [WIDTH-1:0]                r_bin;
  logic [4*NUM_DIGITS-1:0]         r_bcd, w_bcd_adj;
  logic [CW-1:0]                   r_cnt;
  logic                            r_ovf;
  logic                            r_done;
  logic [NUM_DIGITS-1:0][6:0]      r_seg, w_dec, w_seg_nxt;
  logic [NUM_DIGITS-1:0]           w_blank;
  logic                            w_ovf;

  assign w_ovf = {{(32-WIDTH){1'b0}}, iVALUE} > MAX_DISPLAY;

  always_ff @(posedge iCLK or negedge nRST) begin
    if (!nRST) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (iSTART) w_state_nxt = ST_SHIFT;
      ST_SHIFT:  if (r_cnt == CW'(1)) w_state_nxt = ST_ENCODE;
      ST_ENCODE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_to_seg7 u_dec (
      .i_bcd (r_bcd[g*4 +: 4]),
      .o_seg (w_dec[g])
    );
    // A digit blanks only when it and every more-significant digit are zero.
    if (g == 0) begin : g_lsd
      assign w_blank[g] = 1'b0;
    end else begin : g_upper
      assign w_blank[g] = LZ_BLANK && (r_bcd[4*NUM_DIGITS-1:g*4] == '0);
    end
    assign w_seg_nxt[g] = r_ovf      ? SEG_DASH  :
                          w_blank[g] ? SEG_BLANK : w_dec[g];
  end

  always_ff @(posedge iCLK or negedge nRST) begin
    if (!nRST) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
      r_seg  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (iSTART) begin
          r_bin <= iVALUE;
          r_bcd <= '0;
          r_cnt <= CW'(WIDTH);
          r_ovf <= w_ovf;
        end
        ST_SHIFT: begin
          r_bcd <= {w_bcd_adj[4*NUM_DIGITS-2:0], r_bin[WIDTH-1]};
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt - CW'(1);
        end
        ST_ENCODE: begin
          r_seg  <= w_seg_nxt;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign oBUSY = (r_state != ST_IDLE);
  assign oDONE = r_done;
  assign oSEG7 = r_seg[7];
  assign oSEG6 = r_seg[6];
  assign oSEG5 = r_seg[5];
  assign oSEG4 = r_seg[4];
  assign oSEG3 = r_seg[3];
  assign oSEG2 = r_seg[2];
  assign oSEG1 = r_seg[1];
  assign oSEG0 = r_seg[0];

endmodule
